// File: rtl/change_dispenser.sv
// Change dispenser: pays out a latched balance as greedy coins (Rs 10/5/2/1)
// over a valid/ready handshake, with hopper-stall fault detection and recovery.
module change_dispenser #(
  parameter int unsigned JAM_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [4:0] i_balance,
  input  logic       i_coin_ready,
  input  logic       i_clear_fault,
  output logic       o_coin_valid,
  output logic [1:0] o_coin_type,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_fault,
  output logic [4:0] o_remaining,
  output logic [2:0] o_coin_count
);

  localparam int unsigned BAL_W   = 5;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned TYPE_W  = 2;
  localparam int unsigned STALL_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_FAULT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [TYPE_W-1:0] greedy_type(input logic [BAL_W-1:0] amt);
    if (amt >= BAL_W'(10))     greedy_type = 2'b11;
    else if (amt >= BAL_W'(5)) greedy_type = 2'b10;
    else if (amt >= BAL_W'(2)) greedy_type = 2'b01;
    else                       greedy_type = 2'b00;
  endfunction

  function automatic logic [BAL_W-1:0] coin_value(input logic [TYPE_W-1:0] t);
    case (t)
      2'b11:   coin_value = BAL_W'(10);
      2'b10:   coin_value = BAL_W'(5);
      2'b01:   coin_value = BAL_W'(2);
      default: coin_value = BAL_W'(1);
    endcase
  endfunction

  state_t              r_state;
  logic [BAL_W-1:0]    r_remaining;
  logic [CNT_W-1:0]    r_coin_count;
  logic [STALL_W-1:0]  r_stall;
  logic                r_coin_valid;
  logic [TYPE_W-1:0]   r_coin_type;
  logic                r_busy;
  logic                r_done;
  logic                r_fault;

  state_t              w_state_nxt;
  logic [BAL_W-1:0]    w_rem_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [STALL_W-1:0]  w_stall_nxt;
  logic [STALL_W-1:0]  w_stall_inc;
  logic [BAL_W-1:0]    w_rem_after;
  logic                w_coin_valid_nxt;
  logic [TYPE_W-1:0]   w_coin_type_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_fault_nxt;

  // Next-state, datapath and registered-output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_remaining;
    w_cnt_nxt    = r_coin_count;
    w_stall_nxt  = r_stall;
    w_stall_inc  = STALL_W'(r_stall + STALL_W'(1));
    w_rem_after  = BAL_W'(r_remaining - coin_value(greedy_type(r_remaining)));

    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_cnt_nxt   = '0;
          w_stall_nxt = '0;
          if (i_balance != '0) begin
            w_rem_nxt   = i_balance;
            w_state_nxt = S_OFFER;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_OFFER: begin
        if (i_coin_ready) begin
          w_rem_nxt   = w_rem_after;
          w_cnt_nxt   = CNT_W'(r_coin_count + CNT_W'(1));
          w_stall_nxt = '0;
          if (w_rem_after == '0) w_state_nxt = S_DONE;
        end else begin
          w_stall_nxt = w_stall_inc;
          if (w_stall_inc == STALL_W'(JAM_CYCLES)) w_state_nxt = S_FAULT;
        end
      end
      S_FAULT: begin
        if (i_clear_fault) begin
          w_stall_nxt = '0;
          w_state_nxt = S_OFFER;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_coin_valid_nxt = (w_state_nxt == S_OFFER);
    w_busy_nxt       = (w_state_nxt == S_OFFER) || (w_state_nxt == S_FAULT);
    w_done_nxt       = (w_state_nxt == S_DONE);
    w_fault_nxt      = (w_state_nxt == S_FAULT);
    w_coin_type_nxt  = (w_state_nxt == S_OFFER) ? greedy_type(w_rem_nxt) : '0;
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_remaining  <= '0;
      r_coin_count <= '0;
      r_stall      <= '0;
      r_coin_valid <= 1'b0;
      r_coin_type  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_remaining  <= w_rem_nxt;
      r_coin_count <= w_cnt_nxt;
      r_stall      <= w_stall_nxt;
      r_coin_valid <= w_coin_valid_nxt;
      r_coin_type  <= w_coin_type_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_fault      <= w_fault_nxt;
    end
  end

  assign o_coin_valid = r_coin_valid;
  assign o_coin_type  = r_coin_type;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_fault      = r_fault;
  assign o_remaining  = r_remaining;
  assign o_coin_count = r_coin_count;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: driver pushes greedy coin expectations,
// a negedge monitor pops them on each handshake and tracks the stall/fault rule.
module tb_change_dispenser;

  localparam int unsigned JAM = 16;
  localparam int M_READY = 0, M_TOGGLE = 1, M_RAND = 2, M_JAM = 3, M_SPARSE = 4;

  logic       clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_start = 1'b0;
  logic [4:0] i_balance = '0;
  logic       i_coin_ready = 1'b0;
  logic       i_clear_fault = 1'b0;
  logic       o_coin_valid;
  logic [1:0] o_coin_type;
  logic       o_busy;
  logic       o_done;
  logic       o_fault;
  logic [4:0] o_remaining;
  logic [2:0] o_coin_count;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_coin_q[$];
  int         exp_done_q[$];

  change_dispenser #(.JAM_CYCLES(JAM)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_balance(i_balance),
    .i_coin_ready(i_coin_ready), .i_clear_fault(i_clear_fault),
    .o_coin_valid(o_coin_valid), .o_coin_type(o_coin_type), .o_busy(o_busy),
    .o_done(o_done), .o_fault(o_fault), .o_remaining(o_remaining),
    .o_coin_count(o_coin_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rupees(input logic [1:0] t);
    case (t)
      2'b11:   return 10;
      2'b10:   return 5;
      2'b01:   return 2;
      default: return 1;
    endcase
  endfunction

  // Reference: greedy change as a list of coins
  task automatic push_payout(input int bal);
    int rem = bal;
    int n = 0;
    while (rem > 0) begin
      if (rem >= 10)     begin exp_coin_q.push_back(2'b11); rem -= 10; end
      else if (rem >= 5) begin exp_coin_q.push_back(2'b10); rem -= 5;  end
      else if (rem >= 2) begin exp_coin_q.push_back(2'b01); rem -= 2;  end
      else               begin exp_coin_q.push_back(2'b00); rem -= 1;  end
      n++;
    end
    exp_done_q.push_back(n);
  endtask

  // Monitor: compares outputs against the scoreboard and the stall/fault rule
  int m_stall = 0;
  bit m_fault = 0;
  bit m_post_rst = 0;
  always @(negedge clk) begin
    int sum;
    if (!i_reset) begin
      exp_coin_q.delete();
      exp_done_q.delete();
      m_stall = 0;
      m_fault = 0;
      m_post_rst = 1;
    end else begin
      if (m_post_rst) begin
        chk("reset_outputs", int'({o_coin_valid, o_busy, o_done, o_fault,
                                   o_coin_type, o_remaining, o_coin_count}), 0);
        m_post_rst = 0;
      end
      chk("fault", int'(o_fault), int'(m_fault));
      if (m_fault) chk("valid_in_fault", int'(o_coin_valid), 0);
      if (o_coin_valid) begin
        if (exp_coin_q.size() == 0) chk("unexpected_coin", 1, 0);
        else chk("coin_type", int'(o_coin_type), int'(exp_coin_q[0]));
      end
      if (o_busy && exp_done_q.size() != 0) begin
        sum = 0;
        foreach (exp_coin_q[k]) sum += rupees(exp_coin_q[k]);
        chk("remaining", int'(o_remaining), sum);
        chk("coin_count_busy", int'(o_coin_count), exp_done_q[0] - exp_coin_q.size());
      end
      if (o_done) begin
        chk("busy_in_done", int'(o_busy), 0);
        if (exp_done_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          chk("coin_count_done", int'(o_coin_count), exp_done_q.pop_front());
          chk("remaining_done", int'(o_remaining), 0);
          chk("coins_left_at_done", exp_coin_q.size(), 0);
        end
      end
      // Advance the model across the coming edge
      if (i_start && !o_busy && !o_done) m_stall = 0;
      if (o_coin_valid && i_coin_ready) begin
        if (exp_coin_q.size() != 0) void'(exp_coin_q.pop_front());
        m_stall = 0;
      end else if (o_coin_valid && !i_coin_ready) begin
        m_stall++;
        if (m_stall == int'(JAM)) m_fault = 1;
      end
      if (m_fault && i_clear_fault) begin
        m_fault = 0;
        m_stall = 0;
      end
    end
  end

  // Driver: one payout, returns after done (or after a mid-payout reset)
  task automatic run_payout(input int bal, input int mode, input int reset_after,
                            input bit stray);
    bit tog = 1'b1;
    bit jam_seen = 1'b0;
    bit finished = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b1;
    i_balance = 5'(bal);
    push_payout(bal);
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("start_busy", int'(o_busy), int'(bal != 0));
    chk("start_valid", int'(o_coin_valid), int'(bal != 0));
    chk("start_done", int'(o_done), int'(bal == 0));
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      i_start = 1'b0;
      i_clear_fault = 1'b0;
      if (o_done) begin
        i_start = 1'b1;
        i_balance = 5'($urandom_range(1, 31));
        @(posedge clk); #1;
        i_start = 1'b0;
        finished = 1'b1;
      end else if (reset_after >= 0 && o_busy && int'(o_coin_count) == reset_after) begin
        i_reset = 1'b0;
        @(posedge clk); #1;
        i_reset = 1'b1;
        finished = 1'b1;
      end else begin
        case (mode)
          M_READY:  i_coin_ready = 1'b1;
          M_TOGGLE: begin i_coin_ready = tog; tog = ~tog; end
          M_RAND:   i_coin_ready = 1'($urandom_range(0, 1));
          M_JAM:    i_coin_ready = jam_seen;
          default:  i_coin_ready = ($urandom_range(0, 7) == 0);
        endcase
        if (o_fault) begin
          if (mode == M_JAM) begin
            jam_seen = 1'b1;
            i_clear_fault = 1'b1;
            i_coin_ready = 1'b1;
          end else begin
            i_clear_fault = ($urandom_range(0, 2) == 0);
          end
        end else if ($urandom_range(0, 9) == 0) begin
          i_clear_fault = 1'b1;
        end
        if (stray && o_busy && $urandom_range(0, 2) == 0) begin
          i_start = 1'b1;
          i_balance = 5'($urandom_range(0, 31));
        end
        @(posedge clk); #1;
      end
    end
    if (!finished) chk("payout_timeout", 1, 0);
    i_start = 1'b0;
    i_clear_fault = 1'b0;
  endtask

  initial begin
    int mode;
    i_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b1;
    repeat (2) @(posedge clk);

    run_payout(18, M_READY, -1, 1'b0);
    run_payout(29, M_TOGGLE, -1, 1'b0);
    run_payout(0, M_READY, -1, 1'b0);
    run_payout(7, M_JAM, -1, 1'b0);
    run_payout(31, M_READY, 1, 1'b0);
    repeat (2) @(posedge clk);
    run_payout(3, M_READY, -1, 1'b0);
    run_payout(15, M_READY, -1, 1'b1);

    for (int n = 0; n < 60; n++) begin
      mode = $urandom_range(0, 4);
      run_payout($urandom_range(0, 31), mode,
                 ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : -1,
                 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    chk("drain_coins", exp_coin_q.size(), 0);
    chk("drain_done", exp_done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Pays out the change left after a sale as a sequence of coins to the coin hopper. It sits downstream of the vending controller and consumes that block's 5-bit `balance`. On `start` it latches the balance and dispenses coins greedily (Rs 10, 5, 2, 1) over a valid/ready handshake. It counts the coins issued and raises a fault if the hopper stalls.

## Interface
- `JAM_CYCLES`, default 16: consecutive stalled cycles (coin offered, `coin_ready` low) that trigger a fault; legal range 1..255.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-low reset (asserted when 0, sampled on `clk` rising edge).
- `start`  input  1  one-cycle request to pay out `balance`; honoured only in IDLE.
- `balance`  input  5  change to return in rupees (0..31), sampled with `start`.
- `coin_ready`  input  1  hopper accepts the offered coin this cycle.
- `clear_fault`  input  1  leave FAULT and resume dispensing.
- `coin_valid`  output  1  a coin is offered.
- `coin_type`  output  2  offered coin: 00=Rs 1, 01=Rs 2, 10=Rs 5, 11=Rs 10.
- `busy`  output  1  payout in progress (OFFER or FAULT).
- `done`  output  1  one-cycle pulse when payout completes.
- `fault`  output  1  hopper jam detected.
- `remaining`  output  5  rupees still owed.
- `coin_count`  output  3  coins issued in the current or last payout.

## Operation
- States: IDLE, OFFER, FAULT, DONE. Encoding is free.
- **IDLE**
  - `start`=1 and `balance`≠0: latch `remaining`=`balance`, clear `coin_count` and the stall counter, go to OFFER.
  - `start`=1 and `balance`=0: clear `coin_count`, go to DONE.
- **OFFER**
  - `coin_valid`=1. `coin_type` is the greedy choice from `remaining`: ≥10→Rs 10; else ≥5→Rs 5; else ≥2→Rs 2; else Rs 1.
  - Transfer occurs on an edge with `coin_valid`&`coin_ready`. Then `remaining` -= coin value (never underflows), `coin_count`+=1, stall counter cleared.
  - If the post-transfer `remaining` is 0, go to DONE; otherwise stay in OFFER and offer the next coin in the next cycle (back-to-back transfers allowed).
  - `coin_type` and `remaining` are stable while `coin_valid`=1 and no transfer has occurred.
  - On an edge with `coin_ready`=0, the stall counter increments. When it reaches `JAM_CYCLES`, go to FAULT.
- **FAULT**
  - `coin_valid`=0, `fault`=1, `busy`=1. `remaining` and `coin_count` are held.
  - `clear_fault`=1: clear the stall counter and return to OFFER.
- **DONE**
  - `done`=1 and `busy`=0 for exactly one cycle, then go to IDLE unconditionally. `start` in DONE is ignored.
- `start` is ignored outside IDLE; `clear_fault` is ignored outside FAULT.
- The maximum payout is 5 coins (e.g. 28 or 29), so `coin_count` never wraps.
- `coin_count` and `remaining` hold their final values in IDLE until the next `start`.

## Timing
- Reset (`reset`=0 at an edge):
  - state=IDLE;
  - `coin_valid`, `busy`, `done`, `fault` = 0;
  - `coin_type`=00, `remaining`=0, `coin_count`=0;
  - stall counter=0.
- Reset overrides everything, including mid-payout and FAULT. A partially dispensed payout is abandoned.
- Start latency: with `start` sampled at edge T, `busy`=`coin_valid`=1 in the cycle after T.
- Coin-to-coin spacing is 1 cycle when `coin_ready` is held at 1. An N-coin payout with ready always high has `coin_valid` high for N cycles, then `done` in cycle N+1 after the start edge.
- For `balance`=0, `done` pulses in the cycle after the start edge and `coin_valid` never rises.
- Fault timing: the FAULT entry edge is the `JAM_CYCLES`-th consecutive edge with `coin_valid`=1 and `coin_ready`=0. `fault` rises in the following cycle.
- On the edge where `clear_fault` is sampled, `coin_valid` returns to 1 in the next cycle.
- A `coin_ready` pulse while `coin_valid`=0 has no effect.

## Test plan
- `balance`=18, `coin_ready`=1 throughout → `coin_type` 11,10,01,00 on consecutive cycles; `done` on cycle 5; `coin_count`=4, `remaining`=0.
- `balance`=29, `coin_ready` toggling 1,0,1,0… → coins 10,10,5,2,2, one transfer per ready-high edge; `coin_count`=5; `coin_type` stable during stalls.
- `balance`=0 with `start` → `done` pulse next cycle, `coin_valid` never high, `coin_count`=0; a second `start` during DONE is ignored.
- `balance`=7, `coin_ready`=0 for 16 cycles → `fault`=1, `coin_valid`=0, `remaining`=7. Then `clear_fault` with ready=1 → coins 5,2, `done`.
- Reset (`reset`=0) issued after the first coin of `balance`=31 → all outputs 0 next cycle. Then a new `start` with `balance`=3 → coins 2,1.
- `start` pulsed while `busy` with `balance`=15 → ignored; the original payout completes unchanged.
